// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg
//    Shared definitions for the RAM burst master and its read-back checker:
//    default bus widths, the burst FSM state encoding and a saturating
//    counter helper.
//    Optional feature macro used by importers: BURST_VERIFY_EN.
package ram_bus_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;
   localparam int LEN_W_DEF   = 8;
   localparam int ERR_CNT_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } burst_state_e;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      logic [ERR_CNT_W-1:0] r;
      if (v == {ERR_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_burst_checker.sv
// ram_burst_checker
//    One-cycle-delayed compare pipeline for the read-back phase. An accepted
//    read beat captures its expected data and address; on the following cycle
//    the returned read data is compared. Mismatches set a sticky error flag,
//    bump a saturating counter and record the address of the first bad word.
// Ports:
//    clk, reset_n        clock, synchronous active-low reset
//    clear               start of a new burst: drop pending compare, clear errors
//    beat_valid          a read beat is accepted on this edge
//    beat_addr/beat_data address and expected data of that beat
//    rd_data             bus read data (valid one cycle after an accepted beat)
//    err, err_cnt, first_err_addr   error status outputs (registered)
module ram_burst_checker
   import ram_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 beat_valid,
   input  logic [ADDR_W-1:0]    beat_addr,
   input  logic [DATA_W-1:0]    beat_data,
   input  logic [DATA_W-1:0]    rd_data,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    first_err_addr
);

   logic              pend_v_r;
   logic [ADDR_W-1:0] pend_addr_r;
   logic [DATA_W-1:0] pend_data_r;
   logic              mismatch_s;

   // Compare the data returned for the beat accepted on the previous edge.
   always_comb begin
      mismatch_s = 1'b0;
      if (pend_v_r && (rd_data != pend_data_r)) begin
         mismatch_s = 1'b1;
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Pending-beat pipeline and error bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_v_r       <= 1'b0;
         pend_addr_r    <= '0;
         pend_data_r    <= '0;
         err            <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
      end else if (clear) begin
         pend_v_r       <= 1'b0;
         pend_addr_r    <= '0;
         pend_data_r    <= '0;
         err            <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
      end else begin
         // The pipeline keeps running through grant drops: data that arrives
         // after a drop still belongs to the beat accepted before it.
         pend_v_r    <= beat_valid;
         pend_addr_r <= beat_addr;
         pend_data_r <= beat_data;
         if (mismatch_s) begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            if (!err) begin
               first_err_addr <= pend_addr_r;
            end
         end
      end
   end

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
//    Bus master that writes an incrementing pattern (seed+i) to a burst of
//    consecutive word addresses (base_addr+i, wrapping) and, when the verify
//    feature is built in, reads the burst back and checks it.
//    Optional feature macro: BURST_VERIFY_EN (enables the READ/DRAIN verify
//    phase and the ram_burst_checker instance; without it err, err_cnt and
//    first_err_addr are tied to 0 and the FSM goes WRITE -> DONE).
// Ports:
//    clk, reset_n                 clock, synchronous active-low reset
//    start, base_addr, length, seed   burst launch and parameters (length 0 = no-op)
//    M_grant, M_din               bus grant and read data
//    M_req, M_wr, M_address, M_dout   bus request, write strobe, address, write data
//    busy, done                   activity flag, one-cycle completion pulse
//    err, err_cnt, first_err_addr read-back error status
module ram_burst_master
   import ram_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [LEN_W-1:0]     length,
   input  logic [DATA_W-1:0]    seed,
   input  logic                 M_grant,
   input  logic [DATA_W-1:0]    M_din,
   output logic                 M_req,
   output logic                 M_wr,
   output logic [ADDR_W-1:0]    M_address,
   output logic [DATA_W-1:0]    M_dout,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    first_err_addr
);

   burst_state_e      state_r;
   logic [LEN_W-1:0]  idx_r;
   logic [LEN_W-1:0]  len_r;
   logic [ADDR_W-1:0] base_r;
   logic [DATA_W-1:0] seed_r;

   logic [LEN_W-1:0]  next_idx_s;
   logic [ADDR_W-1:0] next_addr_s;
   logic [DATA_W-1:0] next_data_s;
   logic              last_beat_s;

   // Next-beat index, address and data, plus last-beat detect.
   always_comb begin
      next_idx_s  = idx_r + LEN_W'(1);
      next_addr_s = base_r + ADDR_W'(next_idx_s);
      next_data_s = seed_r + DATA_W'(next_idx_s);
      if (idx_r == (len_r - LEN_W'(1))) begin
         last_beat_s = 1'b1;
      end else begin
         last_beat_s = 1'b0;
      end
   end

   // Burst FSM; every bus/status output is registered here so it lines up
   // with the state it belongs to.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         len_r     <= '0;
         base_r    <= '0;
         seed_r    <= '0;
         M_req     <= 1'b0;
         M_wr      <= 1'b0;
         M_address <= '0;
         M_dout    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base_r    <= base_addr;
                  len_r     <= length;
                  seed_r    <= seed;
                  idx_r     <= '0;
                  M_address <= base_addr;
                  M_dout    <= seed;
                  busy      <= 1'b1;
                  if (length == '0) begin
                     state_r <= ST_DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r <= ST_REQ;
                     M_req   <= 1'b1;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_REQ: begin
               // Grant here only opens the burst; no beat is taken in REQ.
               if (M_grant) begin
                  state_r <= ST_WRITE;
                  M_wr    <= 1'b1;
               end
            end
            ST_WRITE: begin
               // Without grant everything holds, so the stalled beat is retried.
               if (M_grant) begin
                  if (last_beat_s) begin
`ifdef BURST_VERIFY_EN
                     state_r   <= ST_READ;
                     idx_r     <= '0;
                     M_wr      <= 1'b0;
                     M_address <= base_r;
                     M_dout    <= seed_r;
`else
                     state_r <= ST_DONE;
                     M_req   <= 1'b0;
                     M_wr    <= 1'b0;
                     done    <= 1'b1;
`endif
                  end else begin
                     idx_r     <= next_idx_s;
                     M_address <= next_addr_s;
                     M_dout    <= next_data_s;
                  end
               end
            end
            ST_READ: begin
               // M_dout carries the expected word so the checker can capture it.
               if (M_grant) begin
                  if (last_beat_s) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     idx_r     <= next_idx_s;
                     M_address <= next_addr_s;
                     M_dout    <= next_data_s;
                  end
               end
            end
            ST_DRAIN: begin
               // One extra cycle so the last read word is compared.
               state_r <= ST_DONE;
               M_req   <= 1'b0;
               done    <= 1'b1;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               M_req   <= 1'b0;
               M_wr    <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef BURST_VERIFY_EN
   logic clear_s;
   logic beat_valid_s;

   assign clear_s      = (state_r == ST_IDLE) && start;
   assign beat_valid_s = (state_r == ST_READ) && M_req && M_grant;

   ram_burst_checker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_checker (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (clear_s),
      .beat_valid     (beat_valid_s),
      .beat_addr      (M_address),
      .beat_data      (M_dout),
      .rd_data        (M_din),
      .err            (err),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );
`else
   // Read data has no consumer when the verify phase is not built.
   logic unused_din_s;
   assign unused_din_s   = ^M_din;
   assign err            = 1'b0;
   assign err_cnt        = '0;
   assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master
//    Table-driven bench for ram_burst_master with a bus/memory model.
//    Expected write beats are queued when a burst is launched and popped as
//    the DUT presents them. Latency is counted in rising edges after the edge
//    that samples start, up to the edge that raises done.
//    Expectations follow BURST_VERIFY_EN when it is defined.
module tb_ram_burst_master;
   import ram_bus_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;
   localparam int LW = LEN_W_DEF;
`ifdef BURST_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] length;
   logic [DW-1:0] seed;
   logic          M_grant;
   logic [DW-1:0] M_din;
   logic          M_req;
   logic          M_wr;
   logic [AW-1:0] M_address;
   logic [DW-1:0] M_dout;
   logic          busy;
   logic          done;
   logic          err;
   logic [7:0]    err_cnt;
   logic [AW-1:0] first_err_addr;

   always #5 clk = ~clk;

   ram_burst_master dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .seed           (seed),
      .M_grant        (M_grant),
      .M_din          (M_din),
      .M_req          (M_req),
      .M_wr           (M_wr),
      .M_address      (M_address),
      .M_dout         (M_dout),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );

   typedef struct {
      logic [AW-1:0] base;
      int            len;
      logic [DW-1:0] seed;
      int            drop_at;
      int            drop_len;
      int            corrupt_idx;
      int            exp_lat;
      bit            exp_err;
      int            exp_cnt;
      logic [AW-1:0] exp_first;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } beat_t;

   beat_t         wq[$];
   logic [DW-1:0] mem [0:255];
   bit            corrupt_en;
   logic [AW-1:0] corrupt_addr;
   int            total = 0;
   int            bad = 0;
   vec_t          vecs [5];
   vec_t          v0;
   vec_t          vab;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   64'(M_req), 64'(0));
      chk({tag, "_wr"},    64'(M_wr), 64'(0));
      chk({tag, "_busy"},  64'(busy), 64'(0));
      chk({tag, "_done"},  64'(done), 64'(0));
      chk({tag, "_err"},   64'(err), 64'(0));
      chk({tag, "_addr"},  64'(M_address), 64'(0));
      chk({tag, "_dout"},  64'(M_dout), 64'(0));
      chk({tag, "_cnt"},   64'(err_cnt), 64'(0));
      chk({tag, "_first"}, 64'(first_err_addr), 64'(0));
   endtask

   // Launch one burst and act as bus slave/memory until done (or abort_at).
   task automatic run_burst(input vec_t v, input int abort_at);
      int            n;
      int            wr_cnt;
      int            dropped;
      bit            seen_done;
      bit            seen_req;
      bit            aborted;
      logic [DW-1:0] rd_hold;
      beat_t         b;
      wq.delete();
      for (int i = 0; i < v.len; i++) begin
         b.a = v.base + AW'(i);
         b.d = v.seed + DW'(i);
         wq.push_back(b);
      end
      corrupt_en   = (v.corrupt_idx >= 0);
      corrupt_addr = v.base + AW'(v.corrupt_idx);
      @(negedge clk);
      base_addr = v.base;
      length    = LW'(v.len);
      seed      = v.seed;
      start     = 1'b1;
      M_grant   = 1'b1;
      rd_hold   = '0;
      n = 0; wr_cnt = 0; dropped = 0;
      seen_done = 1'b0; seen_req = 1'b0; aborted = 1'b0;
      while (!seen_done && !aborted && n < 3000) begin
         @(negedge clk);
         n++;
         M_din = rd_hold;
         start = 1'b0;
         // A start mid-burst must be ignored.
         if (n == 3 && v.len >= 4) begin
            start     = 1'b1;
            base_addr = ~v.base;
            length    = LW'(3);
         end
         if (n == 1) chk("busy_launch", 64'(busy), 64'(1));
         if (M_req) seen_req = 1'b1;
         if (done) begin
            seen_done = 1'b1;
         end else if (abort_at != 0 && n == abort_at) begin
            reset_n = 1'b0;
            aborted = 1'b1;
         end else begin
            if (v.drop_len > 0 && wr_cnt == v.drop_at && dropped < v.drop_len) begin
               M_grant = 1'b0;
               dropped++;
            end else begin
               M_grant = 1'b1;
            end
            if (M_req && M_grant && M_wr) begin
               if (wq.size() == 0) begin
                  chk("wr_extra_beat", 64'(1), 64'(0));
               end else begin
                  b = wq.pop_front();
                  chk("wr_addr", 64'(M_address), 64'(b.a));
                  chk("wr_data", 64'(M_dout), 64'(b.d));
               end
               mem[M_address] = (corrupt_en && M_address == corrupt_addr) ? (M_dout ^ 32'h0000_0001) : M_dout;
               wr_cnt++;
            end
            rd_hold = (M_req && M_grant && !M_wr) ? mem[M_address] : '0;
         end
      end
      if (aborted) begin
         @(negedge clk);
         chk_all_zero("abort");
         chk("abort_no_done", 64'(seen_done), 64'(0));
         reset_n = 1'b1;
         M_grant = 1'b1;
      end else if (!seen_done) begin
         chk("done_timeout", 64'(1), 64'(0));
      end else begin
         chk("latency", 64'(n - 1), 64'(v.exp_lat));
         chk("err", 64'(err), 64'(v.exp_err));
         chk("err_cnt", 64'(err_cnt), 64'(v.exp_cnt));
         chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_first));
         chk("sb_empty", 64'(wq.size()), 64'(0));
         chk("req_seen", 64'(seen_req), 64'(v.len != 0));
         @(negedge clk);
         chk("done_one_cycle", 64'(done), 64'(0));
         chk("idle_busy", 64'(busy), 64'(0));
         chk("idle_req", 64'(M_req), 64'(0));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      corrupt_en = 1'b0; corrupt_addr = '0;
      reset_n = 1'b0; start = 1'b0; M_grant = 1'b0; M_din = '0;
      base_addr = '0; length = '0; seed = '0;

      // base, len, seed, drop_at, drop_len, corrupt_idx, exp_lat, exp_err, exp_cnt, exp_first
      vecs[0] = '{8'h00, 32,  32'h0000_0000, 0, 0, -1, VER ? 66 : 33, 1'b0, 0, 8'h00};
      vecs[1] = '{8'hfe, 4,   32'h1234_5678, 0, 0, -1, VER ? 10 : 5, 1'b0, 0, 8'h00};
      vecs[2] = '{8'h40, 12,  32'ha5a5_0000, 5, 3, -1, VER ? 29 : 16, 1'b0, 0, 8'h00};
      vecs[3] = '{8'h10, 16,  32'h0000_0100, 0, 0, 7, VER ? 34 : 17, VER, VER ? 1 : 0, VER ? 8'h17 : 8'h00};
      vecs[4] = '{8'h80, 255, 32'hffff_fff0, 0, 0, -1, VER ? 512 : 256, 1'b0, 0, 8'h00};
      v0      = '{8'h33, 0,   32'hdead_beef, 0, 0, -1, 0, 1'b0, 0, 8'h00};
      vab     = '{8'h20, 32,  32'h0000_0007, 0, 0, -1, 0, 1'b0, 0, 8'h00};

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         run_burst(vecs[k], 0);
      end

      // Zero-length burst: done on the launch edge's state, no bus request.
      run_burst(v0, 0);

      // Reset mid-burst (in READ when verify is built, else in WRITE), then a clean burst.
      run_burst(vab, VER ? 40 : 10);
      run_burst(vecs[1], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
